// File: rtl/fwd_dest_pipe.sv
// rtl/fwd_dest_pipe.sv - destination-register tracking, EX operand forward selects and load-use stall
// Carries the ID-selected destination through EX/MEM/WB/RET and compares it against the EX sources.
module fwd_dest_pipe #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          freeze,
  input  logic          flush,
  input  logic [AW-1:0] id_dst,
  input  logic          id_we,
  input  logic          id_is_load,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rt,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          load_use
);

  logic [AW-1:0] ex_rs, ex_rt, ex_dst;
  logic          ex_we, ex_ld;
  logic [AW-1:0] mem_dst, wb_dst, ret_dst;
  logic          mem_we, wb_we, ret_we;
  logic          bubble;

  // Youngest producer wins; register 0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != '0) begin
      if (mem_we && (mem_dst == src))      sel = 2'd1;
      else if (wb_we && (wb_dst == src))   sel = 2'd2;
      else if (ret_we && (ret_dst == src)) sel = 2'd3;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_rs);
  assign fwd_b = fwd_sel(ex_rt);

  assign load_use = ex_ld & ex_we & (ex_dst != '0) &
                    ((ex_dst == id_rs) | (id_use_rt & (ex_dst == id_rt)));

  assign bubble = flush | load_use;

  // The load flag is only consulted in EX, so it is not carried past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_dst  <= '0;
      ex_we   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_dst <= '0;
      mem_we  <= 1'b0;
      wb_dst  <= '0;
      wb_we   <= 1'b0;
      ret_dst <= '0;
      ret_we  <= 1'b0;
    end else if (!freeze) begin
      mem_dst <= ex_dst;
      mem_we  <= ex_we;
      wb_dst  <= mem_dst;
      wb_we   <= mem_we;
      ret_dst <= wb_dst;
      ret_we  <= wb_we;
      if (bubble) begin
        ex_rs  <= '0;
        ex_rt  <= '0;
        ex_dst <= '0;
        ex_we  <= 1'b0;
        ex_ld  <= 1'b0;
      end else begin
        ex_rs  <= id_rs;
        ex_rt  <= id_rt;
        ex_dst <= id_dst;
        ex_we  <= id_we;
        ex_ld  <= id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_fwd_dest_pipe.sv
// tb/tb_fwd_dest_pipe.sv - directed and random checks of fwd_dest_pipe against an in-flight instruction list
module tb_fwd_dest_pipe;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          freeze = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] id_dst = '0;
  logic          id_we = 1'b0;
  logic          id_is_load = 1'b0;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic          id_use_rt = 1'b0;
  logic [1:0]    fwd_a, fwd_b;
  logic          load_use;

  int checks = 0;
  int failures = 0;

  fwd_dest_pipe #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    logic          we;
    logic          ld;
  } instr_t;

  // Instructions in flight: index 0 = EX, 1 = MEM, 2 = WB, 3 = RET.
  instr_t pipe [4];

  function automatic int exp_fwd(input logic [AW-1:0] src);
    for (int k = 1; k < 4; k++)
      if (pipe[k].we && pipe[k].dst == src && src != 0) return k;
    return 0;
  endfunction

  function automatic logic exp_lu();
    instr_t e;
    e = pipe[0];
    return e.ld && e.we && e.dst != 0 &&
           (e.dst == id_rs || (id_use_rt && e.dst == id_rt));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) pipe[k] = '0;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".fwd_a"}, int'(fwd_a), exp_fwd(pipe[0].rs));
    chk({tag, ".fwd_b"}, int'(fwd_b), exp_fwd(pipe[0].rt));
    chk({tag, ".load_use"}, int'(load_use), int'(exp_lu()));
  endtask

  // Present an ID instruction (called just after a falling edge) and check outputs against the model.
  task automatic id(input string tag, input logic fr, input logic fl,
                    input logic [AW-1:0] dst, input logic we, input logic ld,
                    input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic urt);
    freeze = fr; flush = fl;
    id_dst = dst; id_we = we; id_is_load = ld;
    id_rs = rs; id_rt = rt; id_use_rt = urt;
    #1;
    chk_model(tag);
  endtask

  // Clock one edge; the model advances from the inputs held across that edge.
  task automatic tick();
    instr_t nxt;
    logic bub;
    bub = flush || exp_lu();
    nxt = bub ? '0 : {id_rs, id_rt, id_dst, id_we, id_is_load};
    @(posedge clk);
    if (!freeze) begin
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    chk("reset.fwd_a", int'(fwd_a), 0);
    chk("reset.load_use", int'(load_use), 0);
    rst_n = 1'b1;

    // Back-to-back ALU forwarding, then one stage older.
    id("t2.i1", 0, 0, 5'd5, 1, 0, 5'd0, 5'd0, 0); tick();
    id("t2.i2", 0, 0, 5'd0, 0, 0, 5'd5, 5'd7, 1); tick();
    chk("t2.fwd_a_mem", int'(fwd_a), 1);
    chk("t2.fwd_b_none", int'(fwd_b), 0);
    id("t2.i3", 0, 0, 5'd0, 0, 0, 5'd5, 5'd0, 0); tick();
    chk("t2.fwd_a_wb", int'(fwd_a), 2);

    // Asynchronous reset between clock edges clears in-flight destinations.
    rst_n = 1'b0;
    #1;
    chk("t1.async_fwd_a", int'(fwd_a), 0);
    chk("t1.async_fwd_b", int'(fwd_b), 0);
    chk("t1.async_load_use", int'(load_use), 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three writers of r9: the newest must win.
    id("t3.i1", 0, 0, 5'd9, 1, 0, 5'd1, 5'd2, 1); tick();
    id("t3.i2", 0, 0, 5'd9, 1, 0, 5'd1, 5'd2, 1); tick();
    id("t3.i3", 0, 0, 5'd9, 1, 0, 5'd1, 5'd2, 1); tick();
    id("t3.i4", 0, 0, 5'd0, 0, 0, 5'd9, 5'd0, 0); tick();
    chk("t3.priority", int'(fwd_a), 1);

    // Load-use on rt: one bubble, then forward from WB.
    id("t4.lw", 0, 0, 5'd8, 1, 1, 5'd0, 5'd0, 0); tick();
    id("t4.dep", 0, 0, 5'd10, 1, 0, 5'd3, 5'd8, 1);
    chk("t4.load_use", int'(load_use), 1);
    tick();
    chk("t4.bubble_fwd_b", int'(fwd_b), 0);
    id("t4.dep2", 0, 0, 5'd10, 1, 0, 5'd3, 5'd8, 1);
    chk("t4.no_stall_after_bubble", int'(load_use), 0);
    tick();
    chk("t4.fwd_b_wb", int'(fwd_b), 2);

    // Register 0 is never forwarded; rt ignored when unused.
    id("t5.w0", 0, 0, 5'd0, 1, 0, 5'd1, 5'd1, 0); tick();
    id("t5.r0", 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 1); tick();
    chk("t5.zero_fwd_a", int'(fwd_a), 0);
    id("t5.lw4", 0, 0, 5'd4, 1, 1, 5'd0, 5'd0, 0); tick();
    id("t5.nort", 0, 0, 5'd0, 0, 0, 5'd1, 5'd4, 0);
    chk("t5.no_use_rt", int'(load_use), 0);
    tick();

    // Freeze holds every stage.
    id("t6.w3", 0, 0, 5'd3, 1, 0, 5'd0, 5'd0, 0); tick();
    id("t6.r3", 0, 0, 5'd0, 0, 0, 5'd3, 5'd0, 0); tick();
    chk("t6.pre_freeze", int'(fwd_a), 1);
    for (int i = 0; i < 3; i++) begin
      id("t6.frz", 1, 0, 5'($urandom), 1, 0, 5'($urandom), 5'($urandom), 1); tick();
      chk("t6.freeze_hold", int'(fwd_a), 1);
    end

    // Flush coinciding with load_use inserts exactly one bubble.
    id("t6.lw6", 0, 0, 5'd6, 1, 1, 5'd0, 5'd0, 0); tick();
    id("t6.flu", 0, 1, 5'd0, 0, 0, 5'd6, 5'd0, 0);
    chk("t6.flush_load_use", int'(load_use), 1);
    tick();
    id("t6.after", 0, 0, 5'd0, 0, 0, 5'd6, 5'd0, 0);
    chk("t6.after_no_stall", int'(load_use), 0);
    tick();
    chk("t6.single_bubble", int'(fwd_a), 2);

    // RET-stage match.
    id("t6.w12", 0, 0, 5'd12, 1, 0, 5'd0, 5'd0, 0); tick();
    id("t6.nop1", 0, 0, 5'd1, 0, 0, 5'd0, 5'd0, 0); tick();
    id("t6.nop2", 0, 0, 5'd1, 0, 0, 5'd0, 5'd0, 0); tick();
    id("t6.r12", 0, 0, 5'd0, 0, 0, 5'd12, 5'd12, 1); tick();
    chk("t6.ret_fwd_a", int'(fwd_a), 3);
    chk("t6.ret_fwd_b", int'(fwd_b), 3);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      id("rnd",
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
         5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end
    chk_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
